// File: rtl/fmul_stream_ctrl_if.sv
// fmul_stream_ctrl_if: operand-pair input stream and result output stream of fmul_stream_ctrl
interface fmul_stream_ctrl_if #(parameter int W = 24);
  logic         s_valid, s_ready, m_valid, m_ready, m_ovf, m_unf;
  logic [W-1:0] s_a, s_b, m_data;
  modport master (output s_valid, s_a, s_b, m_ready, input s_ready, m_valid, m_data, m_ovf, m_unf);
  modport slave  (input s_valid, s_a, s_b, m_ready, output s_ready, m_valid, m_data, m_ovf, m_unf);
endinterface

// File: rtl/fmul_stream_ctrl.sv
// fmul_stream_ctrl: credit-gated issue to a fixed-latency float multiplier with an in-order result FIFO
module fmul_stream_ctrl #(
  parameter int W       = 24,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fmul_stream_ctrl_if.slave      s,
  output logic [W-1:0]           mul_a,
  output logic [W-1:0]           mul_b,
  input  logic [W-1:0]           mul_out,
  input  logic                   mul_ovf,
  input  logic                   mul_unf,
  output logic [$clog2(DEPTH):0] inflight
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [LATENCY:0] vpipe_q, vpipe_d;
  logic [W+1:0]   mem_q [DEPTH];
  logic [W+1:0]   mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic           fire, wr, pop;
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++) inflight += (AW+1)'(vpipe_q[i]);
  end
  // Credit counts both queued results and ops still inside the multiplier, so a write never finds the FIFO full
  assign s.s_ready = rst && (({1'b0, count_q} + {1'b0, inflight}) < (AW+2)'(DEPTH));
  assign s.m_valid = count_q != '0;
  assign {s.m_ovf, s.m_unf, s.m_data} = mem_q[rptr_q];
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  always_comb begin
    fire    = s.s_valid & s.s_ready;
    wr      = vpipe_q[LATENCY];
    pop     = s.m_valid & s.m_ready;
    mul_a_d = fire ? s.s_a : mul_a_q;
    mul_b_d = fire ? s.s_b : mul_b_q;
    vpipe_d = {vpipe_q[LATENCY-1:0], fire};
    mem_d   = mem_q;
    mem_d[wptr_q] = wr ? {mul_ovf, mul_unf, mul_out} : mem_q[wptr_q];
    wptr_d  = wptr_q + AW'(wr);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      vpipe_q <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      vpipe_q <= vpipe_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_fmul_stream_ctrl.sv
// tb_fmul_stream_ctrl: directed stimulus with a queue-based reference model checked every cycle
module tb_fmul_stream_ctrl;
  localparam int W = 24, LATENCY = 3, DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] mul_a, mul_b, mul_out;
  logic mul_ovf, mul_unf;
  logic [2:0] inflight;
  logic [W+1:0] mpipe [LATENCY];
  int n_chk = 0, n_fail = 0;

  fmul_stream_ctrl_if #(.W(W)) bus();

  fmul_stream_ctrl #(.W(W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s(bus.slave),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .mul_ovf(mul_ovf), .mul_unf(mul_unf), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: LATENCY register stages of {a[0], b[0], a^b}
  always @(posedge clk) begin
    mpipe[0] <= {mul_a[0], mul_b[0], mul_a ^ mul_b};
    for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
  end
  assign {mul_ovf, mul_unf, mul_out} = mpipe[LATENCY-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: ops wait LATENCY+1 edges after issue, then sit in an unbounded queue until popped
  typedef struct { logic [W+1:0] v; int t; } ent_t;
  ent_t pend[$];
  logic [W+1:0] q[$];
  ent_t x;
  int e = 0, pops = 0, both = 0;
  logic f_n = 1'b0, pop_n = 1'b0, mr;
  logic [W-1:0] a_n, b_n, last_a, last_b;

  always @(negedge clk) begin
    e++;
    if (!rst) begin
      pend.delete();
      q.delete();
      f_n = 1'b0;
      pop_n = 1'b0;
      last_a = '0;
      last_b = '0;
      chk("rst_m_valid", 32'(bus.m_valid), 0);
      chk("rst_s_ready", 32'(bus.s_ready), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
    end else begin
      if (pop_n) begin void'(q.pop_front()); pops++; end
      if (f_n) begin
        last_a = a_n;
        last_b = b_n;
        pend.push_back('{v: {a_n[0], b_n[0], a_n ^ b_n}, t: e + LATENCY + 1});
      end
      while (pend.size() != 0 && pend[0].t <= e) begin
        x = pend.pop_front();
        q.push_back(x.v);
      end
      mr = (q.size() + pend.size()) < DEPTH;
      chk("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      chk("inflight", 32'(inflight), 32'(pend.size()));
      chk("s_ready", 32'(bus.s_ready), 32'(mr));
      chk("mul_a", 32'(mul_a), 32'(last_a));
      chk("mul_b", 32'(mul_b), 32'(last_b));
      if (q.size() != 0) chk("m_head", 32'({bus.m_ovf, bus.m_unf, bus.m_data}), 32'(q[0]));
      f_n = bus.s_valid && mr;
      a_n = bus.s_a;
      b_n = bus.s_b;
      pop_n = (q.size() != 0) && bus.m_ready;
      if (pop_n && pend.size() != 0 && pend[0].t == e + 1) both++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    logic ok;
    bus.s_valid = 1'b1;
    bus.s_a = a;
    bus.s_b = b;
    do begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!ok && k < 200);
    if (!ok) chk("send_timeout", 0, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_mv(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.m_valid && k < 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, fires, mx, p0;
    logic [W-1:0] exp_d [4];
    logic exp_o [4];
    exp_d = '{24'h000001, 24'h000000, 24'h000001, 24'h000000};
    exp_o = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.s_valid = 1'b0;
    bus.s_a = '0;
    bus.s_b = '0;
    bus.m_ready = 1'b0;
    #1 rst = 1'b0;
    tick(3);
    chk("reset_s_ready", 32'(bus.s_ready), 0);
    chk("reset_m_valid", 32'(bus.m_valid), 0);
    chk("reset_inflight", 32'(inflight), 0);
    rst = 1'b1;
    tick(1);
    // single op latency and flags
    send(24'h3F8000, 24'h000001);
    wait_mv(k);
    chk("single_latency", 32'(k), 5);
    chk("single_data", 32'(bus.m_data), 32'h3F8001);
    chk("single_ovf", 32'(bus.m_ovf), 0);
    chk("single_unf", 32'(bus.m_unf), 1);
    tick(1);
    bus.m_ready = 1'b1;
    tick(1);
    bus.m_ready = 1'b0;
    tick(1);
    // stall fill
    fires = 0;
    mx = 0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.s_a = 24'(i * 3 + 5);
      bus.s_b = 24'(i * 7 + 2);
      @(negedge clk);
      if (bus.s_ready) fires++;
      if (int'(inflight) > mx) mx = int'(inflight);
      tick(1);
    end
    bus.s_valid = 1'b0;
    chk("fill_fires", 32'(fires), 4);
    chk("fill_max_inflight", 32'(mx), 4);
    chk("fill_inflight_drained", 32'(inflight), 0);
    chk("fill_s_ready_low", 32'(bus.s_ready), 0);
    chk("fill_m_valid", 32'(bus.m_valid), 1);
    bus.m_ready = 1'b1;
    tick(6);
    // streaming with downstream always ready
    p0 = pops;
    for (int i = 0; i < 32; i++) send(24'(i * 24'h010203), 24'(i + 7));
    tick(20);
    chk("stream_results", 32'(pops - p0), 32);
    chk("stream_empty", 32'(bus.m_valid), 0);
    // fill, then overlapping push/pop across pointer wrap
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(24'(24'hA00000 + i), 24'(i * 5));
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1;
      bus.s_a = 24'(i * 24'h001357 + 24'h0F0F00);
      bus.s_b = 24'(i * 24'h000931 + 1);
      bus.m_ready = (i % 3) != 0;
      tick(1);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick(12);
    chk("wrap_simultaneous_seen", 32'(both > 0), 1);
    chk("wrap_drained", 32'(bus.m_valid), 0);
    // flag binding
    bus.m_ready = 1'b0;
    send(24'h000001, 24'h000000);
    send(24'h000000, 24'h000000);
    send(24'h000001, 24'h000000);
    send(24'h000000, 24'h000000);
    tick(6);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flag_valid", 32'(bus.m_valid), 1);
      chk("flag_data", 32'(bus.m_data), 32'(exp_d[i]));
      chk("flag_ovf", 32'(bus.m_ovf), 32'(exp_o[i]));
      chk("flag_unf", 32'(bus.m_unf), 0);
      tick(1);
    end
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("flag_empty", 32'(bus.m_valid), 0);
    tick(1);
    // reset with two in flight and two queued
    for (int i = 0; i < 4; i++) send(24'(24'h555000 + i), 24'h000002);
    tick(2);
    chk("pre_rst_inflight", 32'(inflight), 2);
    chk("pre_rst_m_valid", 32'(bus.m_valid), 1);
    rst = 1'b0;
    #1;
    chk("rst_now_m_valid", 32'(bus.m_valid), 0);
    chk("rst_now_inflight", 32'(inflight), 0);
    chk("rst_now_s_ready", 32'(bus.s_ready), 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    send(24'h000ABC, 24'h000003);
    wait_mv(k);
    chk("post_rst_latency", 32'(k), 5);
    chk("post_rst_data", 32'(bus.m_data), 32'h000ABF);
    chk("post_rst_ovf", 32'(bus.m_ovf), 0);
    chk("post_rst_unf", 32'(bus.m_unf), 1);
    tick(1);
    bus.m_ready = 1'b1;
    tick(1);
    bus.m_ready = 1'b0;
    tick(4);
    chk("post_rst_no_stale", 32'(bus.m_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
